// File: rtl/downsample_engine.sv
// downsample_engine: loads a square image, filters it with a 3x3 stride-2 kernel
// ([1 2 1; 2 4 2; 1 2 1] / 16, round half up) and serves the reduced image for readback.
// Host protocol via status: 00 idle, 10 load, 01 process, 11 read.
// Optional build macro DS_MAXPOOL_EN adds a mode_max port selecting a 3x3 max-pool instead.
module downsample_engine #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        status,
  input  logic [PIX_W-1:0]  data,
  input  logic [ADDR_W-1:0] addr,
`ifdef DS_MAXPOOL_EN
  input  logic              mode_max,
`endif
  output logic              end_process,
  output logic [PIX_W-1:0]  out,
  output logic              out_valid
);

  localparam int unsigned OUT_W  = (IMG_W - 3) / 2 + 1;
  localparam int unsigned IMG_N  = IMG_W * IMG_W;
  localparam int unsigned OUT_N  = OUT_W * OUT_W;
  localparam int unsigned IMG_AW = $clog2(IMG_N);
  localparam int unsigned RES_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int unsigned OC_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned ACC_W  = PIX_W + 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TAP,
    S_WRITE,
    S_DONE,
    S_READ
  } state_t;

  state_t state;
  state_t state_nxt;

  // Storage: source image and reduced result (not cleared by reset)
  logic [PIX_W-1:0] img [IMG_N];
  logic [PIX_W-1:0] res [OUT_N];

  // Traversal counters and accumulator
  logic [OC_W-1:0]  ox;
  logic [OC_W-1:0]  oy;
  logic [1:0]       kx;
  logic [1:0]       ky;
  logic [ACC_W-1:0] acc;
`ifdef DS_MAXPOOL_EN
  logic             mode_q;
`endif

  // FSM strobes
  logic start;
  logic tap_step;
  logic res_wr;
  logic done_set;

  // Datapath helpers
  logic              tap_last;
  logic              out_last;
  logic              addr_in_img;
  logic              addr_in_res;
  int unsigned       tap_row;
  int unsigned       tap_col;
  logic [IMG_AW-1:0] tap_addr;
  logic [RES_AW-1:0] res_idx;
  logic [PIX_W-1:0]  pix;
  logic [ACC_W-1:0]  wpix;
  logic [ACC_W-1:0]  rounded;
  logic [PIX_W-1:0]  res_val;
  logic [PIX_W-1:0]  rd_data;

  // Static decodes of counters and host address
  always_comb begin
    tap_last    = (kx == 2'd2) && (ky == 2'd2);
    out_last    = (ox == OC_W'(OUT_W - 1)) && (oy == OC_W'(OUT_W - 1));
    addr_in_img = (32'(addr) < IMG_N);
    addr_in_res = (32'(addr) < OUT_N);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; leaving status=01 mid-run aborts to IDLE
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    tap_step  = 1'b0;
    res_wr    = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      S_TAP: begin
        if (status != ST_PROC) begin
          state_nxt = S_IDLE;
        end else begin
          tap_step = 1'b1;
          if (tap_last) begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (status != ST_PROC) begin
          state_nxt = S_IDLE;
        end else begin
          res_wr = 1'b1;
          if (out_last) begin
            done_set  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_TAP;
          end
        end
      end
      default: begin
        unique case (status)
          ST_LOAD: state_nxt = S_LOAD;
          ST_READ: state_nxt = S_READ;
          ST_PROC: begin
            if (end_process) begin
              state_nxt = S_DONE;
            end else begin
              start     = 1'b1;
              state_nxt = S_TAP;
            end
          end
          default: state_nxt = end_process ? S_DONE : S_IDLE;
        endcase
      end
    endcase
  end

  // Current tap address and weighted pixel (weight = 2^(kx==1) * 2^(ky==1))
  always_comb begin
    tap_row  = 2 * 32'(oy) + 32'(ky);
    tap_col  = 2 * 32'(ox) + 32'(kx);
    tap_addr = IMG_AW'(tap_row * IMG_W + tap_col);
    pix      = img[tap_addr];
    wpix     = ACC_W'(pix);
    if (kx == 2'd1) begin
      wpix = wpix << 1;
    end
    if (ky == 2'd1) begin
      wpix = wpix << 1;
    end
  end

  // Result value and result/read addressing
  always_comb begin
    res_idx = RES_AW'(32'(oy) * OUT_W + 32'(ox));
    rounded = acc + ACC_W'(8);
    res_val = PIX_W'(rounded >> 4);
`ifdef DS_MAXPOOL_EN
    if (mode_q) begin
      res_val = PIX_W'(acc);
    end
`endif
    rd_data = addr_in_res ? res[RES_AW'(addr)] : '0;
  end

  // Image RAM write port; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if ((status == ST_LOAD) && addr_in_img) begin
      img[IMG_AW'(addr)] <= data;
    end
  end

  // Result RAM write port
  always_ff @(posedge clk) begin
    if (res_wr) begin
      res[res_idx] <= res_val;
    end
  end

  // Kernel/output counters and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox  <= '0;
      oy  <= '0;
      kx  <= '0;
      ky  <= '0;
      acc <= '0;
`ifdef DS_MAXPOOL_EN
      mode_q <= 1'b0;
`endif
    end else if (start) begin
      ox  <= '0;
      oy  <= '0;
      kx  <= '0;
      ky  <= '0;
      acc <= '0;
`ifdef DS_MAXPOOL_EN
      mode_q <= mode_max;
`endif
    end else if (tap_step) begin
`ifdef DS_MAXPOOL_EN
      if (mode_q) begin
        acc <= (ACC_W'(pix) > acc) ? ACC_W'(pix) : acc;
      end else begin
        acc <= acc + wpix;
      end
`else
      acc <= acc + wpix;
`endif
      if (kx == 2'd2) begin
        kx <= '0;
        ky <= (ky == 2'd2) ? 2'd0 : ky + 2'd1;
      end else begin
        kx <= kx + 2'd1;
      end
    end else if (res_wr) begin
      acc <= '0;
      if (out_last) begin
        ox <= '0;
        oy <= '0;
      end else if (ox == OC_W'(OUT_W - 1)) begin
        ox <= '0;
        oy <= oy + OC_W'(1);
      end else begin
        ox <= ox + OC_W'(1);
      end
    end
  end

  // Completion flag: set after the final write, cleared by any load cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_process <= 1'b0;
    end else if (status == ST_LOAD) begin
      end_process <= 1'b0;
    end else if (done_set) begin
      end_process <= 1'b1;
    end
  end

  // Registered readback; out holds when not reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (status == ST_READ) begin
      out       <= rd_data;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_downsample_engine.sv
// Directed bench for downsample_engine at IMG_W=8 (OUT_W=3, 9 outputs, 90 process cycles).
module tb_downsample_engine;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic [1:0]        status;
  logic [PIX_W-1:0]  data;
  logic [ADDR_W-1:0] addr;
  logic              mode_max;
  logic              end_process;
  logic [PIX_W-1:0]  out;
  logic              out_valid;

  int n_checks;
  int n_errors;
  int cyc;

  downsample_engine #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .status     (status),
    .data       (data),
    .addr       (addr),
`ifdef DS_MAXPOOL_EN
    .mode_max   (mode_max),
`endif
    .end_process(end_process),
    .out        (out),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_const(input logic [7:0] v);
    status = 2'b10;
    for (int a = 0; a < 64; a++) begin
      addr = 8'(a);
      data = v;
      step();
    end
    status = 2'b00;
    step();
  endtask

  task automatic load_impulse();
    status = 2'b10;
    for (int a = 0; a < 64; a++) begin
      addr = 8'(a);
      data = (a == 18) ? 8'd255 : 8'd0;
      step();
    end
    status = 2'b00;
    step();
  endtask

  // Counts edges after the start edge until end_process rises (bounded)
  task automatic run_process(input string tag);
    status = 2'b01;
    step();
    cyc = 0;
    while (!end_process && cyc < 300) begin
      step();
      cyc++;
    end
    check(tag, 32'(cyc), 32'd90);
  endtask

  task automatic read_check(input string tag, input int idx, input logic [7:0] exp);
    status = 2'b11;
    addr   = 8'(idx);
    step();
    check(tag, 32'(out), 32'(exp));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] imp_exp [9];
    logic [7:0] max_exp [9];
    imp_exp = '{8'd16, 8'd16, 8'd0, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
    max_exp = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    status   = 2'b00;
    data     = '0;
    addr     = '0;
    mode_max = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_end_process", 32'(end_process), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Flat image plus an out-of-range write that must be dropped
    load_const(8'd100);
    status = 2'b10;
    addr   = 8'd64;
    data   = 8'd7;
    step();
    status = 2'b00;
    step();
    run_process("flat_latency");
    repeat (20) step();
    check("done_hold", 32'(end_process), 32'd1);
    for (int i = 0; i < 9; i++) read_check($sformatf("flat_res%0d", i), i, 8'd100);
    read_check("read_oob", 9, 8'd0);
    status = 2'b00;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_out_hold", 32'(out), 32'd0);

    // Abort mid-run, then restart from output 0
    load_const(8'd100);
    check("load_clears_done", 32'(end_process), 32'd0);
    status = 2'b01;
    repeat (40) step();
    status = 2'b00;
    repeat (10) step();
    check("abort_no_done", 32'(end_process), 32'd0);
    run_process("restart_latency");
    read_check("abort_res4", 4, 8'd100);
    read_check("abort_res8", 8, 8'd100);

    // Impulse at row 2, col 2
    load_impulse();
    run_process("imp_latency");
    for (int i = 0; i < 9; i++) read_check($sformatf("imp_res%0d", i), i, imp_exp[i]);

`ifdef DS_MAXPOOL_EN
    // Max-pool over the same impulse
    load_impulse();
    mode_max = 1'b1;
    run_process("max_latency");
    mode_max = 1'b0;
    for (int i = 0; i < 9; i++) read_check($sformatf("max_res%0d", i), i, max_exp[i]);
    load_impulse();
    run_process("gauss_again_latency");
`endif

    // Asynchronous reset in the middle of TAP
    read_check("pre_rst_read", 0, 8'd16);
    status = 2'b00;
    step();
    check("hold_before_rst", 32'(out), 32'd16);
    status = 2'b10;
    addr   = 8'd0;
    data   = 8'd0;
    step();
    status = 2'b01;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_done", 32'(end_process), 32'd0);
    status = 2'b00;
    repeat (2) step();
    rst = 1'b0;
    step();
    run_process("post_rst_latency");
    read_check("post_rst_res0", 0, 8'd16);
    read_check("post_rst_res4", 4, 8'd16);
    status = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
